// File: rtl/lfsr_key_scanner.sv
// Consumer of the LFSR key-address stream: filters addresses >= num_keys and issues each in-range
// address once over valid/ready. Optional dropped-address counter under `LFSR_SCAN_STATS_EN.
module lfsr_key_scanner #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           num_keys,
  input  logic [31:0]           lfsr_addr,
  output logic                  lfsr_en,
  output logic [ADDR_WIDTH-1:0] key_addr,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic                  busy,
  output logic                  pass_done,
  output logic [CNT_WIDTH-1:0]  issued_cnt,
`ifdef LFSR_SCAN_STATS_EN
  output logic [CNT_WIDTH-1:0]  dropped_cnt,
`endif
  output logic [1:0]            state_dbg
);

  // Handshake: a key transfers on any rising edge where key_valid && key_ready; while
  // key_valid && !key_ready, key_addr and key_valid hold. lfsr_en high means the generator
  // value on lfsr_addr is consumed at the next edge.

  localparam int SW = CNT_WIDTH + 1;
  localparam int CW = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [31:0]          nk;
  logic [SW-1:0]        limit;
  logic [SW-1:0]        step_cnt;
  logic [SW-1:0]        step_inc;
  logic [SW-1:0]        limit_new;
  logic [CNT_WIDTH-1:0] issued_inc;
  logic                 accept_start;
  logic                 in_range;
  logic                 load;
  logic                 count_hit;
  logic                 step_hit;

  function automatic logic [5:0] msb_index(input logic [31:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  assign accept_start = (state == S_IDLE) && start;
  assign in_range     = lfsr_addr < nk;
  assign load         = lfsr_en && in_range;
  assign issued_inc   = issued_cnt + CNT_WIDTH'(1);
  assign step_inc     = step_cnt + SW'(1);
  // Limit is the smallest power of two strictly above num_keys.
  assign limit_new    = SW'(1) << (msb_index(num_keys) + 6'd1);
  assign count_hit    = load && (CW'(issued_inc) == CW'(nk));
  assign step_hit     = lfsr_en && (step_inc == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = (num_keys == 32'd0) ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        if (count_hit || step_hit) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!key_valid) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    lfsr_en   = 1'b0;
    busy      = 1'b0;
    pass_done = 1'b0;
    state_dbg = state;
    case (state)
      S_SCAN: begin
        lfsr_en = !key_valid || key_ready;
        busy    = 1'b1;
      end
      S_DRAIN: busy      = 1'b1;
      S_DONE:  pass_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nk         <= '0;
      limit      <= '0;
      step_cnt   <= '0;
      issued_cnt <= '0;
    end else if (accept_start) begin
      nk         <= num_keys;
      limit      <= limit_new;
      step_cnt   <= '0;
      issued_cnt <= '0;
    end else if (lfsr_en) begin
      step_cnt <= step_inc;
      if (in_range) issued_cnt <= issued_inc;
    end
  end

  // One-deep output register; a load can only happen when the slot is free or draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_addr  <= '0;
    end else if (load) begin
      key_valid <= 1'b1;
      key_addr  <= lfsr_addr[ADDR_WIDTH-1:0];
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

`ifdef LFSR_SCAN_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   dropped_cnt <= '0;
    else if (accept_start)       dropped_cnt <= '0;
    else if (lfsr_en && !in_range) dropped_cnt <= dropped_cnt + CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_lfsr_key_scanner.sv
// Bench for lfsr_key_scanner: directed spec scenarios plus randomized passes checked against
// a list-filtering reference model of one scan pass.
module tb_lfsr_key_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] num_keys;
  logic [31:0] lfsr_addr;
  logic        lfsr_en;
  logic [31:0] key_addr;
  logic        key_valid;
  logic        key_ready;
  logic        busy;
  logic        pass_done;
  logic [31:0] issued_cnt;
  logic [1:0]  state_dbg;
`ifdef LFSR_SCAN_STATS_EN
  logic [31:0] dropped_cnt;
`endif

  lfsr_key_scanner #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_keys   (num_keys),
    .lfsr_addr  (lfsr_addr),
    .lfsr_en    (lfsr_en),
    .key_addr   (key_addr),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .pass_done  (pass_done),
    .issued_cnt (issued_cnt),
`ifdef LFSR_SCAN_STATS_EN
    .dropped_cnt(dropped_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] stream_q[$];
  int          exp_steps;
  int          exp_issued;
  int          exp_dropped;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: walk the generator stream, stop once num_keys are kept or the
  // power-of-two step budget above num_keys is used up.
  task automatic build_model(input logic [31:0] nk);
    longint lim;
    lim         = 1;
    exp_steps   = 0;
    exp_issued  = 0;
    exp_dropped = 0;
    exp_q.delete();
    while (lim <= longint'(nk)) lim = lim * 2;
    for (int i = 0; i < stream_q.size(); i++) begin
      if (longint'(exp_steps) >= lim || longint'(exp_issued) >= longint'(nk)) break;
      exp_steps++;
      if (stream_q[i] < nk) begin
        exp_q.push_back(stream_q[i]);
        exp_issued++;
      end else begin
        exp_dropped++;
      end
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 4 cycles after first valid
  task automatic run_pass(input logic [31:0] nk, input int mode, input bit poke, output int done_cyc);
    int idx;
    int seen_steps;
    int stall_left;
    int cyc;
    bit done;
    while (stream_q.size() < 256) stream_q.push_back(32'hFFFF_FFFF);
    build_model(nk);
    idx        = 0;
    seen_steps = 0;
    stall_left = -1;
    cyc        = 0;
    done       = 1'b0;
    @(negedge clk);
    num_keys  = nk;
    start     = 1'b1;
    key_ready = 1'b1;
    lfsr_addr = stream_q[0];
    @(negedge clk);
    start    = 1'b0;
    num_keys = $urandom();
    while (!done && cyc < 2000) begin
      case (mode)
        0: key_ready = 1'b1;
        1: key_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_left < 0 && key_valid) stall_left = 4;
          if (stall_left > 0) begin
            key_ready  = 1'b0;
            stall_left = stall_left - 1;
          end else begin
            key_ready = 1'b1;
          end
        end
      endcase
      start = poke && (cyc == 2);
      if (poke && cyc == 2) num_keys = 32'd1;
      lfsr_addr = (idx < stream_q.size()) ? stream_q[idx] : 32'hFFFF_FFFF;
      #1;
      if (key_valid) begin
        chk("key_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("key_addr", 64'(key_addr), 64'(exp_q[0]));
          if (key_ready) void'(exp_q.pop_front());
        end
        if (!key_ready) chk("stall_lfsr_en", 64'(lfsr_en), 64'd0);
      end
      if (lfsr_en) begin
        idx++;
        seen_steps++;
      end
      if (pass_done) done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start    = 1'b0;
    done_cyc = cyc;
    chk("pass_done_seen", 64'(done), 64'd1);
    if (done) begin
      chk("done_busy", 64'(busy), 64'd0);
      chk("done_valid", 64'(key_valid), 64'd0);
      chk("issued_cnt", 64'(issued_cnt), 64'(exp_issued));
      chk("steps", 64'(seen_steps), 64'(exp_steps));
      chk("keys_left", 64'(exp_q.size()), 64'd0);
`ifdef LFSR_SCAN_STATS_EN
      chk("dropped_cnt", 64'(dropped_cnt), 64'(exp_dropped));
`endif
      @(negedge clk);
      #1;
      chk("pass_done_pulse", 64'(pass_done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("issued_hold", 64'(issued_cnt), 64'(exp_issued));
    end
  endtask

  initial begin
    int dc;
    logic [31:0] nk;
    reset     = 1'b1;
    start     = 1'b0;
    num_keys  = '0;
    lfsr_addr = '0;
    key_ready = 1'b0;
    #2;
    chk("rst_lfsr_en", 64'(lfsr_en), 64'd0);
    chk("rst_key_valid", 64'(key_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pass_done", 64'(pass_done), 64'd0);
    chk("rst_key_addr", 64'(key_addr), 64'd0);
    chk("rst_issued", 64'(issued_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // basic stream, ready always high
    stream_q = '{32'd3, 32'd9, 32'd0, 32'd7, 32'd4, 32'd1, 32'd2};
    run_pass(32'd5, 0, 1'b0, dc);
    chk("t1_issued", 64'(issued_cnt), 64'd5);

    // downstream stall after first valid
    stream_q = '{32'd3, 32'd9, 32'd0, 32'd7, 32'd4, 32'd1, 32'd2};
    run_pass(32'd5, 2, 1'b0, dc);

    // empty key table: straight to DONE, pulse in the cycle after start is taken
    stream_q = '{32'd0, 32'd1};
    run_pass(32'd0, 0, 1'b0, dc);
    chk("t3_done_cycle", 64'(dc), 64'd0);

    // nothing in range: watchdog at 8 steps
    stream_q = '{32'd6, 32'd7, 32'd9, 32'd100, 32'd6, 32'd255, 32'd8, 32'd31};
    run_pass(32'd6, 0, 1'b0, dc);
    chk("t4_issued", 64'(issued_cnt), 64'd0);

    // count hit and step limit on the same edge
    stream_q = '{32'd1, 32'd0};
    run_pass(32'd1, 1, 1'b0, dc);
    chk("t_edge_issued", 64'(issued_cnt), 64'd1);

    // power-of-two key count
    stream_q.delete();
    for (int i = 0; i < 20; i++) stream_q.push_back(32'($urandom_range(0, 20)));
    run_pass(32'd8, 1, 1'b0, dc);

    // reset in the middle of a pass
    @(negedge clk);
    num_keys  = 32'd5;
    start     = 1'b1;
    key_ready = 1'b0;
    lfsr_addr = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    lfsr_addr = 32'd9;
    #1;
    chk("pre_rst_valid", 64'(key_valid), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(key_valid), 64'd0);
    chk("mid_rst_lfsr_en", 64'(lfsr_en), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_key_addr", 64'(key_addr), 64'd0);
    chk("mid_rst_issued", 64'(issued_cnt), 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    key_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_done", 64'(pass_done), 64'd0);
    end
    stream_q = '{32'd3, 32'd9, 32'd0, 32'd7, 32'd4, 32'd1, 32'd2};
    run_pass(32'd5, 0, 1'b0, dc);

    // start pulsed mid-scan must be ignored
    stream_q = '{32'd3, 32'd9, 32'd0, 32'd7, 32'd4, 32'd1, 32'd2};
    run_pass(32'd5, 0, 1'b1, dc);
    chk("t6_issued", 64'(issued_cnt), 64'd5);
`ifdef LFSR_SCAN_STATS_EN
    chk("t6_dropped", 64'(dropped_cnt), 64'd2);
`endif

    // randomized passes
    for (int p = 0; p < 8; p++) begin
      nk = 32'($urandom_range(1, 40));
      stream_q.delete();
      for (int i = 0; i < 128; i++) begin
        if ($urandom_range(0, 1) != 0) stream_q.push_back(32'($urandom_range(0, 2 * int'(nk))));
        else stream_q.push_back($urandom());
      end
      run_pass(nk, 1, (p % 3) == 0, dc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
